// File: rtl/uart_pkg.sv
// Shared UART constants used by the baud generator and the TX/RX blocks.
// Defaults target 50 MHz, 9600 baud, x16 oversampling.
package uart_pkg;

    localparam int OS_RATE     = 16;
    localparam int DEFAULT_DIV = 325;
    localparam int MIN_DIV     = 1;

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample and bit-phase tick generator for the UART TX/RX blocks.
// Divisor changes made while counting are held until the next bit boundary.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int OS_RATE     = uart_pkg::OS_RATE,
    parameter int DEFAULT_DIV = uart_pkg::DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    input  logic             sync,
    output logic             os_tick,
    output logic             mid_tick,
    output logic             bit_tick,
    output logic             cfg_err
);

    localparam int PH_W = $clog2(OS_RATE);
    localparam logic [PH_W-1:0]  PH_MID   = PH_W'(OS_RATE / 2 - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OS_RATE - 1);
    localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(MIN_DIV);

    logic [DIV_W-1:0] os_cnt_q, os_cnt_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] div_pend_q, div_pend_d;
    logic             pend_q, pend_d;
    logic             cfg_err_q, cfg_err_d;
    logic             os_tick_q, os_tick_d;
    logic             mid_tick_q, mid_tick_d;
    logic             bit_tick_q, bit_tick_d;

    logic             wrap;
    logic             mid_wrap;
    logic             bit_wrap;
    logic [DIV_W-1:0] div_fix;

    // >= rather than == so a divisor shrunk while disabled cannot leave the count stranded above it
    always_comb begin
        wrap     = en && !sync && (os_cnt_q >= div_q);
        mid_wrap = wrap && (ph_q == PH_MID);
        bit_wrap = wrap && (ph_q == PH_LAST);
        div_fix  = (div == '0) ? DIV_MIN : div;

        os_cnt_d   = os_cnt_q;
        ph_d       = ph_q;
        div_d      = div_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;
        cfg_err_d  = cfg_err_q;

        if (sync) begin
            os_cnt_d = '0;
            ph_d     = '0;
        end else if (wrap) begin
            os_cnt_d = '0;
            ph_d     = ph_q + 1'b1;
        end else if (en) begin
            os_cnt_d = os_cnt_q + 1'b1;
        end

        if (bit_wrap && pend_q) begin
            div_d  = div_pend_q;
            pend_d = 1'b0;
        end

        // A load lands at once wherever no bit is being timed; otherwise it waits for the bit edge
        if (load) begin
            cfg_err_d  = (div == '0);
            div_pend_d = div_fix;
            if (sync || !en || bit_wrap) begin
                div_d  = div_fix;
                pend_d = 1'b0;
            end else begin
                pend_d = 1'b1;
            end
        end

        os_tick_d  = wrap;
        mid_tick_d = mid_wrap;
        bit_tick_d = bit_wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            os_cnt_q   <= '0;
            ph_q       <= '0;
            div_q      <= DIV_RST;
            div_pend_q <= DIV_RST;
            pend_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            os_tick_q  <= 1'b0;
            mid_tick_q <= 1'b0;
            bit_tick_q <= 1'b0;
        end else begin
            os_cnt_q   <= os_cnt_d;
            ph_q       <= ph_d;
            div_q      <= div_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            cfg_err_q  <= cfg_err_d;
            os_tick_q  <= os_tick_d;
            mid_tick_q <= mid_tick_d;
            bit_tick_q <= bit_tick_d;
        end
    end

    assign os_tick  = os_tick_q;
    assign mid_tick = mid_tick_q;
    assign bit_tick = bit_tick_q;
    assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen with OS_RATE=4, DEFAULT_DIV=3.
// Cycle k means the state seen after the k-th rising edge following reset release.
module tb_uart_baud_gen;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] div;
    logic        load;
    logic        sync;
    logic        os_tick;
    logic        mid_tick;
    logic        bit_tick;
    logic        cfg_err;

    int checks;
    int errors;

    uart_baud_gen #(
        .DIV_W      (16),
        .OS_RATE    (4),
        .DEFAULT_DIV(3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .div     (div),
        .load    (load),
        .sync    (sync),
        .os_tick (os_tick),
        .mid_tick(mid_tick),
        .bit_tick(bit_tick),
        .cfg_err (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leaves reset released on a falling edge with en=1, so the next rising edge is cycle 1
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        load  = 1'b0;
        sync  = 1'b0;
        div   = '0;
        repeat (2) @(negedge clk);
        en    = 1'b1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({os_tick, mid_tick, bit_tick, cfg_err} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_idle got %b exp 0000", {os_tick, mid_tick, bit_tick, cfg_err});
        end
        en   = 1'b1;
        load = 1'b1;
        div  = '0;
        repeat (12) @(negedge clk);
        checks++;
        if ({os_tick, mid_tick, bit_tick, cfg_err} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_held got %b exp 0000", {os_tick, mid_tick, bit_tick, cfg_err});
        end
        load = 1'b0;
    endtask

    task automatic test_basic();
        logic [2:0] exp;
        do_reset();
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            exp = {k % 4 == 0, k % 16 == 8, k % 16 == 0};
            checks++;
            if ({os_tick, mid_tick, bit_tick} !== exp) begin
                errors++;
                $display("[TB] FAIL basic cycle %0d os/mid/bit got %b exp %b", k, {os_tick, mid_tick, bit_tick}, exp);
            end
        end
    endtask

    // Two loads mid-bit: the later one (div=1) must win and only take effect at the cycle-16 bit edge
    task automatic test_load_deferred();
        logic [2:0] exp;
        int j;
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            load = (k == 3) || (k == 6);
            div  = (k == 3) ? 16'd7 : 16'd1;
            @(negedge clk);
            if (k <= 16) begin
                exp = {k % 4 == 0, k == 8, k == 16};
            end else begin
                j   = k - 16;
                exp = {j % 2 == 0, j % 8 == 4, j % 8 == 0};
            end
            checks++;
            if ({os_tick, mid_tick, bit_tick} !== exp) begin
                errors++;
                $display("[TB] FAIL load_deferred cycle %0d os/mid/bit got %b exp %b", k, {os_tick, mid_tick, bit_tick}, exp);
            end
        end
        load = 1'b0;
    endtask

    // Second sync lands exactly on a wrap edge, so that tick must be swallowed
    task automatic test_sync();
        logic [2:0] exp;
        int j;
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            sync = (k == 9) || (k == 21);
            @(negedge clk);
            if (k <= 9) begin
                exp = {k % 4 == 0, k == 8, 1'b0};
            end else if (k <= 21) begin
                j   = k - 9;
                exp = {(j % 4 == 0) && (k != 21), j == 8, 1'b0};
            end else begin
                j   = k - 21;
                exp = {j % 4 == 0, j % 16 == 8, j % 16 == 0};
            end
            checks++;
            if ({os_tick, mid_tick, bit_tick} !== exp) begin
                errors++;
                $display("[TB] FAIL sync cycle %0d os/mid/bit got %b exp %b", k, {os_tick, mid_tick, bit_tick}, exp);
            end
        end
        sync = 1'b0;
    endtask

    task automatic test_sync_load();
        logic [2:0] exp;
        int j;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            sync = (k == 6);
            load = (k == 6);
            div  = 16'd1;
            @(negedge clk);
            if (k <= 6) begin
                exp = {k == 4, 1'b0, 1'b0};
            end else begin
                j   = k - 6;
                exp = {j % 2 == 0, j % 8 == 4, j % 8 == 0};
            end
            checks++;
            if ({os_tick, mid_tick, bit_tick} !== exp) begin
                errors++;
                $display("[TB] FAIL sync_load cycle %0d os/mid/bit got %b exp %b", k, {os_tick, mid_tick, bit_tick}, exp);
            end
        end
        sync = 1'b0;
        load = 1'b0;
    endtask

    task automatic test_cfg_err();
        logic [3:0] exp;
        logic       exp_os;
        do_reset();
        for (int k = 1; k <= 50; k++) begin
            en   = !(k >= 25 && k <= 27);
            load = (k == 2) || (k == 25);
            div  = (k == 25) ? 16'd5 : 16'd0;
            @(negedge clk);
            if (k <= 16)      exp_os = (k % 4 == 0);
            else if (k <= 24) exp_os = (k % 2 == 0);
            else if (k <= 32) exp_os = 1'b0;
            else              exp_os = ((k - 27) % 6 == 0);
            exp = {exp_os, (k == 8) || (k == 20) || (k == 39), (k == 16) || (k == 24), (k >= 2) && (k <= 24)};
            checks++;
            if ({os_tick, mid_tick, bit_tick, cfg_err} !== exp) begin
                errors++;
                $display("[TB] FAIL cfg_err cycle %0d os/mid/bit/err got %b exp %b", k, {os_tick, mid_tick, bit_tick, cfg_err}, exp);
            end
        end
        load = 1'b0;
        en   = 1'b1;
    endtask

    task automatic test_enable();
        logic [2:0] exp;
        int j;
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            en = !(k >= 6 && k <= 12);
            @(negedge clk);
            if (k <= 12) begin
                exp = {k == 4, 1'b0, 1'b0};
            end else begin
                j   = k - 7;
                exp = {j % 4 == 0, j % 16 == 8, j % 16 == 0};
            end
            checks++;
            if ({os_tick, mid_tick, bit_tick} !== exp) begin
                errors++;
                $display("[TB] FAIL enable cycle %0d os/mid/bit got %b exp %b", k, {os_tick, mid_tick, bit_tick}, exp);
            end
        end
        en = 1'b1;
    endtask

    // Reset hits while os_tick and mid_tick are high, alongside a load of 0 and a sync
    task automatic test_reset_midbit();
        logic [3:0] exp;
        do_reset();
        repeat (8) @(negedge clk);
        load  = 1'b1;
        sync  = 1'b1;
        div   = '0;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({os_tick, mid_tick, bit_tick, cfg_err} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_midbit_async got %b exp 0000", {os_tick, mid_tick, bit_tick, cfg_err});
        end
        repeat (2) @(negedge clk);
        load  = 1'b0;
        sync  = 1'b0;
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp = {k % 4 == 0, k == 8, k == 16, 1'b0};
            checks++;
            if ({os_tick, mid_tick, bit_tick, cfg_err} !== exp) begin
                errors++;
                $display("[TB] FAIL reset_midbit cycle %0d os/mid/bit/err got %b exp %b", k, {os_tick, mid_tick, bit_tick, cfg_err}, exp);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        en     = 1'b0;
        load   = 1'b0;
        sync   = 1'b0;
        div    = '0;
        test_reset();
        test_basic();
        test_load_deferred();
        test_sync();
        test_sync_load();
        test_cfg_err();
        test_enable();
        test_reset_midbit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
